adc_acq_sequencer: RTL and testbench
====================================

Name: adc_acq_sequencer

Overview:
- Receiving end of the trigger interface. Consumes the single-cycle trigger pulse and 3-bit sub-word from the ADC trigger block.
- Sequences one acquisition into a circular 64-bit-word sample buffer: pre-trigger fill, armed wait, post-trigger count, done.
- Generates the buffer write-enable and write address, and latches the trigger word address and sub-word for software readout.

Parameters:
- ADDR_W, 12, width of the buffer word address; buffer depth is 2^ADDR_W words of 8 samples each.

Ports:
- adc_data_clk  in  1  sample-word clock, shared with the trigger block
- adc_data_resetn  in  1  asynchronous active-low reset
- trigger_in  in  1  single-cycle trigger pulse
- trigger_sub_word  in  3  sample index within the word at the trigger
- acq_arm  in  1  start request; rising edge is detected internally
- acq_abort  in  1  level; returns to IDLE
- pre_words  in  ADDR_W  pre-trigger words to capture before arming
- post_words  in  ADDR_W  words to capture after the trigger word
- wr_en  out  1  buffer write strobe for the current adc_bus word
- wr_addr  out  ADDR_W  buffer write address
- trig_addr  out  ADDR_W  wr_addr of the word in which the trigger occurred
- trig_sub  out  3  latched trigger_sub_word
- acq_state  out  3  IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4
- acq_done  out  1  level; high in DONE
- trig_ignored  out  1  sticky; trigger seen while in PRE

Behaviour:
- Reset value of all outputs: 0. State resets to IDLE. The internal arm edge register resets to 0.
- Arm edge: acq_arm is high this cycle and was low last cycle.
  - Accepted only in IDLE or DONE.
  - Ignored in PRE, ARMED and POST.
- On accepted arm, the next cycle:
  - wr_addr=0, pre counter=0, acq_done=0, trig_ignored=0.
  - trig_addr and trig_sub are held.
  - State becomes PRE if pre_words!=0, otherwise ARMED.
- wr_en is a function of state only: high in PRE, ARMED and POST, low in IDLE and DONE.
- wr_addr increments by 1 on every cycle with wr_en=1 and wraps from 2^ADDR_W-1 to 0.
- PRE:
  - Pre counter increments each cycle.
  - After exactly pre_words PRE cycles, go to ARMED.
  - trigger_in in any PRE cycle, including the last one, sets trig_ignored and is otherwise discarded.
- ARMED:
  - On trigger_in=1: latch trig_addr=wr_addr and trig_sub=trigger_sub_word for that cycle, clear the post counter, go to POST.
  - Latched values are visible one cycle after the trigger pulse.
- POST:
  - Post counter increments each cycle.
  - After exactly post_words POST cycles, go to DONE. post_words=0 gives zero POST cycles: ARMED goes straight to DONE.
  - trigger_in is ignored.
- Total words written = pre_words + (ARMED cycles) + post_words. The trigger word is the final ARMED word.
- DONE: acq_done=1, wr_en=0. Held until the next accepted arm or abort.
- acq_abort=1 in any state:
  - Next cycle: IDLE, wr_en=0, acq_done=0.
  - trig_addr, trig_sub and trig_ignored are held.
  - Abort has priority over arm and trigger in the same cycle.
- Asynchronous reset mid-acquisition: all outputs return to 0 immediately; the state machine returns to IDLE.
- pre_words and post_words are sampled live; they must be static while a capture is in progress.

Optional Feature:
- Macro: ACQ_AUTO_TRIG_EN.
- With the macro defined, the block adds:
  - Input auto_timeout [31:0].
  - Output trig_auto [0:0].
  - A 32-bit counter that clears on entry to ARMED and increments each ARMED cycle.
- Auto-trigger behaviour:
  - Fires when auto_timeout!=0, the counter equals auto_timeout, and there is no real trigger that cycle.
  - Effect: trig_addr=wr_addr, trig_sub=0, trig_auto=1, go to POST, exactly as for a real trigger.
  - A real trigger in the same cycle wins and gives trig_auto=0.
  - trig_auto clears on an accepted arm.
- Without the macro: these ports and the counter are absent, and ARMED waits indefinitely.

Test Plan:
1. Reset, arm, pre_words=4, post_words=3, trigger_in pulse 2 cycles after reaching ARMED with sub=5 -> wr_en high for 10 cycles, trig_addr=6, trig_sub=5, acq_done=1, final wr_addr=10.
2. pre_words=4, trigger pulses on PRE cycle 2 and on the last PRE cycle -> trig_ignored=1, still ARMED; later trigger with sub=3 latched normally.
3. ADDR_W=4, pre_words=14, trigger on the 3rd ARMED cycle, post_words=5 -> trig_addr=0 (wrapped), final wr_addr=6 after the wrap, acq_done=1.
4. Abort asserted mid-POST, with a simultaneous arm edge -> IDLE next cycle, wr_en=0, acq_done=0; arm ignored; new arm then starts PRE with wr_addr=0.
5. pre_words=0, post_words=0, arm then trigger with sub=7 on the first ARMED cycle -> one word written, trig_addr=0, trig_sub=7, DONE the next cycle; arm pulses during ARMED are ignored.
6. ACQ_AUTO_TRIG_EN defined, auto_timeout=20, no trigger -> POST entered on ARMED cycle 21, trig_auto=1, trig_sub=0; rerun with a real trigger on the same cycle -> trig_auto=0.

Source files
------------

// File: rtl/adc_acq_sequencer.sv
// Acquisition sequencer for the circular ADC sample buffer: pre-trigger fill, armed wait,
// post-trigger count, done. Optional auto-trigger timeout is enabled by ACQ_AUTO_TRIG_EN.
module adc_acq_sequencer #(
  parameter int ADDR_W = 12
) (
  input  logic              adc_data_clk,
  input  logic              adc_data_resetn,
  input  logic              trigger_in,
  input  logic [2:0]        trigger_sub_word,
  input  logic              acq_arm,
  input  logic              acq_abort,
  input  logic [ADDR_W-1:0] pre_words,
  input  logic [ADDR_W-1:0] post_words,
`ifdef ACQ_AUTO_TRIG_EN
  input  logic [31:0]       auto_timeout,
  output logic [0:0]        trig_auto,
`endif
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [2:0]        trig_sub,
  output logic [2:0]        acq_state,
  output logic              acq_done,
  output logic              trig_ignored
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            state_reg,     state_next;
  logic              arm_d_reg;
  logic [ADDR_W-1:0] wr_addr_reg,   wr_addr_next;
  logic [ADDR_W-1:0] pre_cnt_reg,   pre_cnt_next;
  logic [ADDR_W-1:0] post_cnt_reg,  post_cnt_next;
  logic [ADDR_W-1:0] trig_addr_reg, trig_addr_next;
  logic [2:0]        trig_sub_reg,  trig_sub_next;
  logic              trig_ign_reg,  trig_ign_next;
  logic              trig_auto_reg, trig_auto_next;

  logic              arm_edge;
  logic              auto_fire;
  logic              wr_en_int;
  logic [ADDR_W-1:0] pre_cnt_inc;
  logic [ADDR_W-1:0] post_cnt_inc;

  assign arm_edge     = acq_arm & ~arm_d_reg;
  assign wr_en_int    = (state_reg == ST_PRE) || (state_reg == ST_ARMED) || (state_reg == ST_POST);
  assign pre_cnt_inc  = pre_cnt_reg + 1'b1;
  assign post_cnt_inc = post_cnt_reg + 1'b1;

`ifdef ACQ_AUTO_TRIG_EN
  logic [31:0] auto_cnt_reg, auto_cnt_next;

  // A real trigger in the same cycle always takes precedence over the timeout.
  assign auto_fire = (state_reg == ST_ARMED) && (auto_timeout != 32'd0) &&
                     (auto_cnt_reg == auto_timeout) && !trigger_in;

  always_comb begin
    auto_cnt_next = auto_cnt_reg;
    if (state_reg == ST_ARMED)
      auto_cnt_next = auto_cnt_reg + 32'd1;
    else if (state_next == ST_ARMED)
      auto_cnt_next = 32'd0;
  end

  always_ff @(posedge adc_data_clk or negedge adc_data_resetn) begin
    if (!adc_data_resetn)
      auto_cnt_reg <= 32'd0;
    else
      auto_cnt_reg <= auto_cnt_next;
  end

  assign trig_auto = trig_auto_reg;
`else
  assign auto_fire = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    wr_addr_next   = wr_en_int ? wr_addr_reg + 1'b1 : wr_addr_reg;
    pre_cnt_next   = pre_cnt_reg;
    post_cnt_next  = post_cnt_reg;
    trig_addr_next = trig_addr_reg;
    trig_sub_next  = trig_sub_reg;
    trig_ign_next  = trig_ign_reg;
    trig_auto_next = trig_auto_reg;

    if (acq_abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (arm_edge) begin
            wr_addr_next   = '0;
            pre_cnt_next   = '0;
            trig_ign_next  = 1'b0;
            trig_auto_next = 1'b0;
            state_next     = (pre_words != '0) ? ST_PRE : ST_ARMED;
          end
        end
        ST_PRE: begin
          pre_cnt_next = pre_cnt_inc;
          if (trigger_in)
            trig_ign_next = 1'b1;
          if (pre_cnt_inc == pre_words)
            state_next = ST_ARMED;
        end
        ST_ARMED: begin
          if (trigger_in || auto_fire) begin
            trig_addr_next = wr_addr_reg;
            trig_sub_next  = trigger_in ? trigger_sub_word : 3'd0;
            trig_auto_next = auto_fire;
            post_cnt_next  = '0;
            state_next     = (post_words == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          post_cnt_next = post_cnt_inc;
          if (post_cnt_inc == post_words)
            state_next = ST_DONE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge adc_data_clk or negedge adc_data_resetn) begin
    if (!adc_data_resetn) begin
      state_reg     <= ST_IDLE;
      arm_d_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      pre_cnt_reg   <= '0;
      post_cnt_reg  <= '0;
      trig_addr_reg <= '0;
      trig_sub_reg  <= 3'd0;
      trig_ign_reg  <= 1'b0;
      trig_auto_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      arm_d_reg     <= acq_arm;
      wr_addr_reg   <= wr_addr_next;
      pre_cnt_reg   <= pre_cnt_next;
      post_cnt_reg  <= post_cnt_next;
      trig_addr_reg <= trig_addr_next;
      trig_sub_reg  <= trig_sub_next;
      trig_ign_reg  <= trig_ign_next;
      trig_auto_reg <= trig_auto_next;
    end
  end

  assign wr_en        = wr_en_int;
  assign wr_addr      = wr_addr_reg;
  assign trig_addr    = trig_addr_reg;
  assign trig_sub     = trig_sub_reg;
  assign acq_state    = state_reg;
  assign acq_done     = (state_reg == ST_DONE);
  assign trig_ignored = trig_ign_reg;

`ifndef ACQ_AUTO_TRIG_EN
  logic unused_auto;
  assign unused_auto = trig_auto_reg;
`endif

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Directed bench for adc_acq_sequencer (ADDR_W=4 so the address wrap is reachable);
// auto-trigger cases run only when ACQ_AUTO_TRIG_EN is defined.
module tb_adc_acq_sequencer;

  localparam int AW = 4;

  logic          adc_data_clk = 1'b0;
  logic          adc_data_resetn;
  logic          trigger_in;
  logic [2:0]    trigger_sub_word;
  logic          acq_arm;
  logic          acq_abort;
  logic [AW-1:0] pre_words;
  logic [AW-1:0] post_words;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] trig_addr;
  logic [2:0]    trig_sub;
  logic [2:0]    acq_state;
  logic          acq_done;
  logic          trig_ignored;
`ifdef ACQ_AUTO_TRIG_EN
  logic [31:0]   auto_timeout;
  logic [0:0]    trig_auto;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;
  int wr_cnt  = 0;

  always #5 adc_data_clk = ~adc_data_clk;

  adc_acq_sequencer #(.ADDR_W(AW)) dut (
    .adc_data_clk     (adc_data_clk),
    .adc_data_resetn  (adc_data_resetn),
    .trigger_in       (trigger_in),
    .trigger_sub_word (trigger_sub_word),
    .acq_arm          (acq_arm),
    .acq_abort        (acq_abort),
    .pre_words        (pre_words),
    .post_words       (post_words),
`ifdef ACQ_AUTO_TRIG_EN
    .auto_timeout     (auto_timeout),
    .trig_auto        (trig_auto),
`endif
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .trig_addr        (trig_addr),
    .trig_sub         (trig_sub),
    .acq_state        (acq_state),
    .acq_done         (acq_done),
    .trig_ignored     (trig_ignored)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    chk_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  // One clock edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge adc_data_clk);
    #1;
    if (wr_en) wr_cnt++;
  endtask

  initial begin
    adc_data_resetn  = 1'b0;
    trigger_in       = 1'b0;
    trigger_sub_word = 3'd0;
    acq_arm          = 1'b0;
    acq_abort        = 1'b0;
    pre_words        = '0;
    post_words       = '0;
`ifdef ACQ_AUTO_TRIG_EN
    auto_timeout     = 32'd0;
`endif
    tick();
    tick();
    check_val("rst_state",     acq_state,    0);
    check_val("rst_wr_en",     wr_en,        0);
    check_val("rst_wr_addr",   wr_addr,      0);
    check_val("rst_trig_addr", trig_addr,    0);
    check_val("rst_trig_sub",  trig_sub,     0);
    check_val("rst_done",      acq_done,     0);
    check_val("rst_ignored",   trig_ignored, 0);
    adc_data_resetn = 1'b1;

    // 1: pre=4, post=3, trigger on the 3rd ARMED cycle
    pre_words = 4; post_words = 3; wr_cnt = 0;
    acq_arm = 1'b1; tick(); acq_arm = 1'b0;
    check_val("t1_pre_state", acq_state, 1);
    check_val("t1_pre_addr",  wr_addr,   0);
    repeat (4) tick();
    check_val("t1_armed",     acq_state, 2);
    tick(); tick();
    trigger_in = 1'b1; trigger_sub_word = 3'd5; tick(); trigger_in = 1'b0;
    check_val("t1_post",      acq_state, 3);
    check_val("t1_trig_addr", trig_addr, 6);
    check_val("t1_trig_sub",  trig_sub,  5);
    repeat (3) tick();
    check_val("t1_done_state", acq_state, 4);
    check_val("t1_done",       acq_done,  1);
    check_val("t1_wr_en",      wr_en,     0);
    check_val("t1_wr_addr",    wr_addr,   10);
    check_val("t1_wr_cnt",     wr_cnt,    10);

    // 2: triggers during PRE are flagged and dropped
    acq_arm = 1'b1; tick(); acq_arm = 1'b0;
    check_val("t2_ign_clr", trig_ignored, 0);
    tick();
    trigger_in = 1'b1; tick(); trigger_in = 1'b0;
    check_val("t2_ign_set", trig_ignored, 1);
    tick();
    trigger_in = 1'b1; tick(); trigger_in = 1'b0;
    check_val("t2_armed",      acq_state, 2);
    check_val("t2_ign_hold",   trig_ignored, 1);
    check_val("t2_taddr_hold", trig_addr, 6);
    trigger_in = 1'b1; trigger_sub_word = 3'd3; tick(); trigger_in = 1'b0;
    check_val("t2_trig_addr", trig_addr, 4);
    check_val("t2_trig_sub",  trig_sub,  3);
    repeat (3) tick();
    check_val("t2_done",    acq_done, 1);
    check_val("t2_wr_addr", wr_addr,  8);

    // 3: address wrap with pre=14, trigger on 3rd ARMED cycle, post=5
    pre_words = 14; post_words = 5;
    acq_arm = 1'b1; tick(); acq_arm = 1'b0;
    repeat (13) tick();
    check_val("t3_last_pre", acq_state, 1);
    tick(); tick(); tick();
    check_val("t3_armed_addr", wr_addr, 0);
    trigger_in = 1'b1; trigger_sub_word = 3'd2; tick(); trigger_in = 1'b0;
    check_val("t3_trig_addr", trig_addr, 0);
    repeat (5) tick();
    check_val("t3_done",    acq_done, 1);
    check_val("t3_wr_addr", wr_addr,  6);

    // 4: abort mid-POST with a simultaneous arm edge
    pre_words = 2; post_words = 5;
    acq_arm = 1'b1; tick(); acq_arm = 1'b0;
    trigger_in = 1'b1; tick(); trigger_in = 1'b0;
    tick();
    trigger_in = 1'b1; trigger_sub_word = 3'd4; tick(); trigger_in = 1'b0;
    tick();
    check_val("t4_in_post", acq_state, 3);
    acq_abort = 1'b1; acq_arm = 1'b1; tick(); acq_abort = 1'b0;
    check_val("t4_idle",      acq_state,    0);
    check_val("t4_wr_en",     wr_en,        0);
    check_val("t4_done",      acq_done,     0);
    check_val("t4_taddr",     trig_addr,    2);
    check_val("t4_tsub",      trig_sub,     4);
    check_val("t4_ign_hold",  trig_ignored, 1);
    tick();
    check_val("t4_arm_level", acq_state, 0);
    acq_arm = 1'b0; tick();
    acq_arm = 1'b1; tick(); acq_arm = 1'b0;
    check_val("t4_rearm_pre",  acq_state, 1);
    check_val("t4_rearm_addr", wr_addr,   0);
    acq_abort = 1'b1; tick(); acq_abort = 1'b0;
    check_val("t4_abort_pre", acq_state, 0);

    // 5: pre=0, post=0, single-word capture; then arm pulses in ARMED
    pre_words = 0; post_words = 0; wr_cnt = 0;
    acq_arm = 1'b1; tick(); acq_arm = 1'b0;
    check_val("t5_armed", acq_state, 2);
    trigger_in = 1'b1; trigger_sub_word = 3'd7; tick(); trigger_in = 1'b0;
    check_val("t5_done",      acq_state, 4);
    check_val("t5_trig_addr", trig_addr, 0);
    check_val("t5_trig_sub",  trig_sub,  7);
    check_val("t5_wr_cnt",    wr_cnt,    1);
    acq_arm = 1'b1; tick(); acq_arm = 1'b0;
    tick();
    acq_arm = 1'b1; tick(); acq_arm = 1'b0;
    check_val("t5_arm_ign_state", acq_state, 2);
    check_val("t5_arm_ign_addr",  wr_addr,   2);
    trigger_in = 1'b1; trigger_sub_word = 3'd1; tick(); trigger_in = 1'b0;
    check_val("t5b_trig_addr", trig_addr, 2);
    check_val("t5b_done",      acq_done,  1);

`ifdef ACQ_AUTO_TRIG_EN
    // 6: auto-trigger after 20 ARMED cycles, then a real trigger on that same cycle
    pre_words = 0; post_words = 2; auto_timeout = 32'd20;
    acq_arm = 1'b1; tick(); acq_arm = 1'b0;
    check_val("t6_armed", acq_state, 2);
    repeat (20) tick();
    check_val("t6_cycle21", acq_state, 2);
    tick();
    check_val("t6_post",      acq_state, 3);
    check_val("t6_auto",      trig_auto, 1);
    check_val("t6_trig_sub",  trig_sub,  0);
    check_val("t6_trig_addr", trig_addr, 4);
    tick(); tick();
    check_val("t6_done", acq_done, 1);
    acq_arm = 1'b1; tick(); acq_arm = 1'b0;
    check_val("t6b_auto_clr", trig_auto, 0);
    repeat (20) tick();
    trigger_in = 1'b1; trigger_sub_word = 3'd6; tick(); trigger_in = 1'b0;
    check_val("t6b_post",     acq_state, 3);
    check_val("t6b_auto",     trig_auto, 0);
    check_val("t6b_trig_sub", trig_sub,  6);
    tick(); tick();
`endif

    // Asynchronous reset in the middle of a capture
    pre_words = 3; post_words = 1;
    acq_arm = 1'b1; tick(); acq_arm = 1'b0;
    tick();
    check_val("ar_pre", acq_state, 1);
    #2 adc_data_resetn = 1'b0;
    #1;
    check_val("ar_state",     acq_state, 0);
    check_val("ar_wr_en",     wr_en,     0);
    check_val("ar_wr_addr",   wr_addr,   0);
    check_val("ar_trig_addr", trig_addr, 0);
    check_val("ar_trig_sub",  trig_sub,  0);
    adc_data_resetn = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
